// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared 25 MHz tick counts for the LED blinker and button debouncer.
package button_debouncer_pkg;
    localparam logic [23:0] BLINK_TOP_25M    = 24'hBE_BC1F;
    localparam logic [23:0] DEBOUNCE_TOP_25M = 24'h03_FFFF;
    localparam logic [23:0] LONG_TOP_25M     = 24'hFF_FFFF;
endpackage

// File: rtl/button_debouncer_sync2.sv
// sync2: generic 2-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= {RST_VAL, RST_VAL};
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces one pushbutton, emitting press/release/short/long strobes.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter logic        BTN_ACTIVE   = 1'b0,
    parameter logic [23:0] DEBOUNCE_TOP = DEBOUNCE_TOP_25M,
    parameter logic [23:0] LONG_TOP     = LONG_TOP_25M
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;
    logic        pin, s, rise, fall;
    logic [23:0] dcnt, hcnt;
    logic [1:0]  state;
    sync2 #(.RST_VAL(~BTN_ACTIVE)) u_sync (.clk(clk), .reset(reset), .d(btn_i), .q(pin));
    // Registered, polarity-normalized sample: 1 = pressed.
    always_ff @(posedge clk or posedge reset)
        if (reset) s <= 1'b0;
        else       s <= ~(pin ^ BTN_ACTIVE);
    assign rise = (dcnt == '0) &&  s && !level_o;
    assign fall = (dcnt == '0) && !s &&  level_o;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            level_o <= 1'b0;
            dcnt    <= DEBOUNCE_TOP;
        end else if (s == level_o) begin
            dcnt    <= DEBOUNCE_TOP;
        end else if (dcnt == '0) begin
            level_o <= s;
            dcnt    <= DEBOUNCE_TOP;
        end else begin
            dcnt    <= dcnt - 24'd1;
        end
    // Strobes fire on the same edge that updates level_o; release wins over hold expiry.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            hcnt      <= LONG_TOP;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                IDLE:
                    if (rise) begin
                        press_o <= 1'b1;
                        hcnt    <= LONG_TOP;
                        state   <= HELD;
                    end
                HELD:
                    if (fall) begin
                        release_o <= 1'b1;
                        short_o   <= 1'b1;
                        state     <= IDLE;
                    end else if (hcnt == '0) begin
                        long_o <= 1'b1;
                        state  <= LONG;
                    end else begin
                        hcnt <= hcnt - 24'd1;
                    end
                LONG:
                    if (fall) begin
                        release_o <= 1'b1;
                        state     <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed vectors for the debouncer with DEBOUNCE_TOP=4, LONG_TOP=20, active-low pin.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_i = 1'b0;
    logic level_o, press_o, release_o, short_o, long_o;
    int cyc = 0;
    int n_press = 0, n_release = 0, n_short = 0, n_long = 0, n_level_hi = 0;
    int t_press = 0, t_release = 0, t_long = 0;
    int n_vec = 0, n_bad = 0;

    button_debouncer #(.BTN_ACTIVE(1'b0), .DEBOUNCE_TOP(24'd4), .LONG_TOP(24'd20)) dut (
        .clk(clk), .reset(reset), .btn_i(btn_i), .level_o(level_o),
        .press_o(press_o), .release_o(release_o), .short_o(short_o), .long_o(long_o)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cyc equals the index of the edge that produced the outputs.
    always @(negedge clk) begin
        if (press_o)   begin n_press++;   t_press = cyc;   end
        if (release_o) begin n_release++; t_release = cyc; end
        if (short_o)   n_short++;
        if (long_o)    begin n_long++;    t_long = cyc;    end
        if (level_o)   n_level_hi++;
    end

    typedef struct {
        int low;
        int e_press;
        int e_rel;
        int e_short;
        int e_long;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        btn_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int p0);
        for (int k = 0; k < 40 && n_press == p0; k++) @(negedge clk);
    endtask

    initial begin
        int t0, p0, r0, s0, l0, h0;
        vecs[0] = '{3, 0, 0, 0, 0};
        vecs[1] = '{4, 0, 0, 0, 0};
        vecs[2] = '{5, 1, 1, 1, 0};
        vecs[3] = '{7, 1, 1, 1, 0};
        vecs[4] = '{15, 1, 1, 1, 0};
        vecs[5] = '{20, 1, 1, 1, 0};
        vecs[6] = '{21, 1, 1, 1, 0};
        vecs[7] = '{40, 1, 1, 0, 1};

        // Reset with the button already pressed
        reset = 1'b1;
        btn_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {level_o, press_o, release_o, short_o, long_o}, 0);
        reset = 1'b0;
        t0 = cyc + 1;
        wait_press(0);
        check("reset_press_time", t_press, t0 + 7);
        hold(0, 10);
        check("reset_press_once", n_press, 1);
        check("reset_level", level_o, 1);
        hold(1, 30);
        check("reset_released", level_o, 0);

        // Bounce rejection
        p0 = n_press; r0 = n_release; h0 = n_level_hi;
        for (int i = 0; i < 5; i++) begin
            hold(0, 3);
            hold(1, 1);
        end
        hold(1, 10);
        check("bounce_strobes", (n_press - p0) + (n_release - r0), 0);
        check("bounce_level", n_level_hi - h0, 0);
        t0 = cyc + 1;
        hold(0, 7);
        hold(1, 30);
        check("bounce_then_press", n_press - p0, 1);
        check("bounce_press_time", t_press, t0 + 7);

        // Table of hold lengths
        for (int i = 0; i < 8; i++) begin
            p0 = n_press; r0 = n_release; s0 = n_short; l0 = n_long;
            t0 = cyc + 1;
            hold(0, vecs[i].low);
            hold(1, 40);
            check($sformatf("v%0d_press", i), n_press - p0, vecs[i].e_press);
            check($sformatf("v%0d_release", i), n_release - r0, vecs[i].e_rel);
            check($sformatf("v%0d_short", i), n_short - s0, vecs[i].e_short);
            check($sformatf("v%0d_long", i), n_long - l0, vecs[i].e_long);
            check($sformatf("v%0d_level", i), level_o, 0);
            if (vecs[i].e_press != 0) begin
                check($sformatf("v%0d_press_time", i), t_press, t0 + 7);
                check($sformatf("v%0d_release_time", i), t_release - t_press, vecs[i].low);
            end
            if (vecs[i].e_long != 0)
                check($sformatf("v%0d_long_time", i), t_long - t_press, 21);
        end

        // Reset while held: no release, fresh press afterwards
        p0 = n_press;
        hold(0, 10);
        check("mid_first_press", n_press - p0, 1);
        r0 = n_release;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset_outputs", {level_o, press_o, release_o, short_o, long_o}, 0);
        p0 = n_press;
        reset = 1'b0;
        t0 = cyc + 1;
        wait_press(p0);
        check("mid_repress", n_press - p0, 1);
        check("mid_repress_time", t_press, t0 + 7);
        check("mid_no_release", n_release - r0, 0);
        hold(1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
